// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the multi-cycle controller and the
// MIPS datapath. The controller is the master; the datapath is the slave.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             PCWrite;
    logic             IRWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [2:0]       ALUop;
    logic             ALUmux;
    logic             EXTop;
    logic [1:0]       A3mux;
    logic [1:0]       REGmux;
    logic [1:0]       NPCsel;
    logic             md_start;
    logic [1:0]       md_op;
    logic             hilo_sel;
    logic             busy;
    logic             instr_done;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, zero,
        output PCWrite, IRWrite, RegWrite, MemWrite, ALUop, ALUmux, EXTop,
               A3mux, REGmux, NPCsel, md_start, md_op, hilo_sel, busy,
               instr_done, retired
    );

    modport slave (
        output instr, zero,
        input  PCWrite, IRWrite, RegWrite, MemWrite, ALUop, ALUmux, EXTop,
               A3mux, REGmux, NPCsel, md_start, md_op, hilo_sel, busy,
               instr_done, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit. Walks each IR instruction through
// FETCH/DECODE/EXEC/MEM/WB (plus MDWAIT for mult/div), drives the datapath
// muxes and write enables combinationally from state and IR, and counts
// retired instructions.
module mc_ctrl #(
    parameter int MD_LAT = 5,
    parameter int CNT_W  = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    localparam int MCW = $clog2(MD_LAT + 1);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, MDWAIT
    } state_t;

    // Instruction classes that share a state path.
    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_JALR, C_MD
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b100;

    state_t           state;
    logic [MCW-1:0]   md_cnt;
    logic [CNT_W-1:0] retired;

    logic [5:0]       op;
    logic [5:0]       funct;
    cls_t             cls;
    logic [2:0]       alu_op;
    logic             alu_mux;
    logic             ext_op;
    logic [1:0]       a3_mux;
    logic [1:0]       reg_mux;
    logic             hilo;

    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic             mem_we;
    logic [1:0]       npc_sel;
    logic             md_go;
    logic             done;
    logic             md_last;
    logic             static_en;

    logic             unused_instr_bits;

    assign op    = bus.instr[31:26];
    assign funct = bus.instr[5:0];
    assign unused_instr_bits = ^bus.instr[25:6];

    // A count of 0 can only be seen if MDWAIT is entered illegally; treat it
    // as the last cycle so the FSM can never stall there.
    assign md_last = (md_cnt <= MCW'(1));

    // Decode the IR into a path class and the static datapath controls.
    always_comb begin
        cls     = C_NOP;
        alu_op  = ALU_ADD;
        alu_mux = 1'b0;
        ext_op  = 1'b0;
        a3_mux  = 2'b00;
        reg_mux = 2'b00;
        hilo    = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: cls = C_ALU;
                    6'b100011: begin
                        cls    = C_ALU;
                        alu_op = ALU_SUB;
                    end
                    6'b001000: cls = C_JR;
                    6'b001001: begin
                        cls     = C_JALR;
                        reg_mux = 2'b10;
                    end
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: cls = C_MD;
                    6'b010000: begin
                        cls     = C_ALU;
                        reg_mux = 2'b11;
                        hilo    = 1'b1;
                    end
                    6'b010010: begin
                        cls     = C_ALU;
                        reg_mux = 2'b11;
                    end
                    default: cls = C_NOP;
                endcase
            end
            6'b001101: begin
                cls     = C_ALU;
                alu_op  = ALU_OR;
                alu_mux = 1'b1;
                a3_mux  = 2'b01;
            end
            6'b001111: begin
                cls     = C_ALU;
                alu_op  = ALU_LUI;
                alu_mux = 1'b1;
                a3_mux  = 2'b01;
            end
            6'b001000: begin
                cls     = C_ALU;
                alu_mux = 1'b1;
                ext_op  = 1'b1;
                a3_mux  = 2'b01;
            end
            6'b100011: begin
                cls     = C_LW;
                alu_mux = 1'b1;
                ext_op  = 1'b1;
                a3_mux  = 2'b01;
                reg_mux = 2'b01;
            end
            6'b101011: begin
                cls     = C_SW;
                alu_mux = 1'b1;
                ext_op  = 1'b1;
            end
            6'b000100: begin
                cls    = C_BEQ;
                alu_op = ALU_SUB;
                ext_op = 1'b1;
            end
            6'b000010: cls = C_J;
            6'b000011: begin
                cls     = C_JAL;
                a3_mux  = 2'b10;
                reg_mux = 2'b10;
            end
            default: cls = C_NOP;
        endcase
    end

    // Per-state enables and pulses; everything is forced low during reset.
    always_comb begin
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        npc_sel = 2'b00;
        md_go   = 1'b0;
        done    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
                DECODE: begin
                    case (cls)
                        C_J: begin
                            pc_we   = 1'b1;
                            npc_sel = 2'b10;
                            done    = 1'b1;
                        end
                        C_JR: begin
                            pc_we   = 1'b1;
                            npc_sel = 2'b11;
                            done    = 1'b1;
                        end
                        C_NOP:   done = 1'b1;
                        default: done = 1'b0;
                    endcase
                end
                EXEC: begin
                    if (cls == C_BEQ) begin
                        pc_we   = bus.zero;
                        npc_sel = 2'b01;
                        done    = 1'b1;
                    end
                    md_go = (cls == C_MD);
                end
                MEM: begin
                    mem_we = (cls == C_SW);
                    done   = (cls == C_SW);
                end
                WB: begin
                    reg_we = 1'b1;
                    done   = 1'b1;
                    if (cls == C_JAL) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'b10;
                    end else if (cls == C_JALR) begin
                        pc_we   = 1'b1;
                        npc_sel = 2'b11;
                    end
                end
                MDWAIT:  done = md_last;
                default: done = 1'b0;
            endcase
        end
    end

    // Static controls are only meaningful from DECODE onward; hold them at
    // zero in FETCH and in reset so the datapath sees a quiet bus there.
    assign static_en = !reset && (state != FETCH);

    assign bus.PCWrite    = pc_we;
    assign bus.IRWrite    = ir_we;
    assign bus.RegWrite   = reg_we;
    assign bus.MemWrite   = mem_we;
    assign bus.NPCsel     = npc_sel;
    assign bus.md_start   = md_go;
    assign bus.instr_done = done;
    assign bus.busy       = !reset && (state == MDWAIT);
    assign bus.ALUop      = static_en ? alu_op  : 3'b000;
    assign bus.ALUmux     = static_en ? alu_mux : 1'b0;
    assign bus.EXTop      = static_en ? ext_op  : 1'b0;
    assign bus.A3mux      = static_en ? a3_mux  : 2'b00;
    assign bus.REGmux     = static_en ? reg_mux : 2'b00;
    assign bus.hilo_sel   = static_en ? hilo    : 1'b0;
    assign bus.md_op      = (static_en && cls == C_MD) ? funct[1:0] : 2'b00;
    assign bus.retired    = retired;

    // Sequencer: state register, mult/div wait counter and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            md_cnt  <= '0;
            retired <= '0;
        end else begin
            if (done) retired <= retired + CNT_W'(1);
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    case (cls)
                        C_ALU, C_LW, C_SW, C_BEQ, C_MD: state <= EXEC;
                        C_JAL, C_JALR:                  state <= WB;
                        default:                        state <= FETCH;
                    endcase
                end
                EXEC: begin
                    case (cls)
                        C_ALU:      state <= WB;
                        C_LW, C_SW: state <= MEM;
                        C_MD: begin
                            state  <= MDWAIT;
                            md_cnt <= MCW'(MD_LAT);
                        end
                        default:    state <= FETCH;
                    endcase
                end
                MEM: state <= (cls == C_LW) ? WB : FETCH;
                WB:  state <= FETCH;
                MDWAIT: begin
                    if (md_last) begin
                        state  <= FETCH;
                        md_cnt <= '0;
                    end else begin
                        md_cnt <= md_cnt - MCW'(1);
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
